// File: rtl/memu_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, EXU bus
// field layout and the FSM state encoding.
package memu_pkg;

    // Load/store size codes as carried in funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Control states of the stage
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } memu_state_e;

    // EXU bus layout, LSB upward: regW, regAddr, aluRes, stData, memAddr,
    // funct3, wen, ren. Widths follow the module parameters.
    function automatic int ex_bus_width(input int aw, input int dw);
        return 3 * dw + aw + 6;
    endfunction

    function automatic int wb_bus_width(input int aw, input int dw);
        return dw + aw + 1;
    endfunction

    function automatic int off_regaddr(input int aw, input int dw);
        return 1 + 0 * (aw + dw);
    endfunction

    function automatic int off_alures(input int aw, input int dw);
        return 1 + aw + 0 * dw;
    endfunction

    function automatic int off_stdata(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

    function automatic int off_memaddr(input int aw, input int dw);
        return 1 + aw + 2 * dw;
    endfunction

    function automatic int off_funct3(input int aw, input int dw);
        return 1 + aw + 3 * dw;
    endfunction

    function automatic int off_wen(input int aw, input int dw);
        return 4 + aw + 3 * dw;
    endfunction

    function automatic int off_ren(input int aw, input int dw);
        return 5 + aw + 3 * dw;
    endfunction

    // An access is misaligned when its natural alignment is violated;
    // unknown load sizes behave as words.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] off,
                                           input logic       is_load);
        logic mis;
        mis = 1'b0;
        if (is_load) begin
            case (f3)
                F3_B, F3_BU: mis = 1'b0;
                F3_H, F3_HU: mis = off[0];
                default:     mis = (off != 2'b00);
            endcase
        end else begin
            case (f3[1:0])
                2'b00:   mis = 1'b0;
                2'b01:   mis = off[0];
                default: mis = (off != 2'b00);
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/memu_lsfmt.sv
// Combinational byte-lane logic: store data/mask placement and load
// data extraction with sign or zero extension.
module memu_lsfmt
    import memu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            off,
    input  logic                  is_load,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wmask,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{off, 3'b000} +: 8];
    assign half_sel = rdata[{off[1], 4'b0000} +: 16];

    // Replicate store data across lanes and strobe only the addressed ones
    always_comb begin
        wdata = st_data;
        wmask = 4'b0000;
        if (!is_load) begin
            case (funct3[1:0])
                2'b00: begin
                    wdata = {(DATA_WIDTH / 8){st_data[7:0]}};
                    wmask = 4'b0001 << off;
                end
                2'b01: begin
                    wdata = {(DATA_WIDTH / 16){st_data[15:0]}};
                    wmask = 4'b0011 << {off[1], 1'b0};
                end
                default: begin
                    wdata = st_data;
                    wmask = 4'b1111;
                end
            endcase
        end
    end

    // Pick the addressed byte/half out of the read word and extend it
    always_comb begin
        ld_data = rdata;
        case (funct3)
            F3_B:    ld_data = {{(DATA_WIDTH - 8){byte_sel[7]}}, byte_sel};
            F3_H:    ld_data = {{(DATA_WIDTH - 16){half_sel[15]}}, half_sel};
            F3_BU:   ld_data = {{(DATA_WIDTH - 8){1'b0}}, byte_sel};
            F3_HU:   ld_data = {{(DATA_WIDTH - 16){1'b0}}, half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/memu.sv
// Memory-access stage: takes one op from EXU, performs at most one
// data-memory access and hands the write-back result to WBU.
module memu
    import memu_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [ex_bus_width(ADDR_WIDTH, DATA_WIDTH)-1:0] ex_to_mem_bus,
    input  logic                                       ex_to_mem_valid,
    output logic                                       mem_to_ex_ready,
    output logic [wb_bus_width(ADDR_WIDTH, DATA_WIDTH)-1:0] mem_to_wb_bus,
    output logic                                       mem_to_wb_valid,
    input  logic                                       wb_to_mem_ready,
    output logic                                       dmem_req_valid,
    input  logic                                       dmem_req_ready,
    output logic                                       dmem_req_wen,
    output logic [DATA_WIDTH-1:0]                      dmem_req_addr,
    output logic [DATA_WIDTH-1:0]                      dmem_req_wdata,
    output logic [3:0]                                 dmem_req_wmask,
    input  logic                                       dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0]                      dmem_resp_rdata,
    output logic                                       dmem_resp_ready,
    output logic                                       mem_misalign
);

    localparam int RA_LSB = off_regaddr(ADDR_WIDTH, DATA_WIDTH);
    localparam int AL_LSB = off_alures(ADDR_WIDTH, DATA_WIDTH);
    localparam int SD_LSB = off_stdata(ADDR_WIDTH, DATA_WIDTH);
    localparam int MA_LSB = off_memaddr(ADDR_WIDTH, DATA_WIDTH);
    localparam int F3_LSB = off_funct3(ADDR_WIDTH, DATA_WIDTH);
    localparam int WE_BIT = off_wen(ADDR_WIDTH, DATA_WIDTH);
    localparam int RE_BIT = off_ren(ADDR_WIDTH, DATA_WIDTH);

    // Incoming bus fields
    logic                  in_ren, in_wen, in_regw;
    logic [2:0]            in_funct3;
    logic [DATA_WIDTH-1:0] in_memaddr, in_stdata, in_alures;
    logic [ADDR_WIDTH-1:0] in_regaddr;

    assign in_ren     = ex_to_mem_bus[RE_BIT];
    assign in_wen     = ex_to_mem_bus[WE_BIT];
    assign in_funct3  = ex_to_mem_bus[F3_LSB +: 3];
    assign in_memaddr = ex_to_mem_bus[MA_LSB +: DATA_WIDTH];
    assign in_stdata  = ex_to_mem_bus[SD_LSB +: DATA_WIDTH];
    assign in_alures  = ex_to_mem_bus[AL_LSB +: DATA_WIDTH];
    assign in_regaddr = ex_to_mem_bus[RA_LSB +: ADDR_WIDTH];
    assign in_regw    = ex_to_mem_bus[0];

    // State and latched operation
    memu_state_e           state_q, state_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] st_q, st_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  regw_q, regw_d;
    logic                  load_q, load_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_rd_q, out_rd_d;
    logic                  out_w_q, out_w_d;
    logic                  misalign_q, misalign_d;

    logic                  accept;
    logic [DATA_WIDTH-1:0] fmt_wdata, fmt_ld;
    logic [3:0]            fmt_wmask;

    memu_lsfmt #(.DATA_WIDTH(DATA_WIDTH)) u_lsfmt (
        .funct3  (funct3_q),
        .off     (addr_q[1:0]),
        .is_load (load_q),
        .st_data (st_q),
        .rdata   (dmem_resp_rdata),
        .wdata   (fmt_wdata),
        .wmask   (fmt_wmask),
        .ld_data (fmt_ld)
    );

    assign mem_to_ex_ready = (state_q == ST_IDLE) ||
                             ((state_q == ST_OUT) && wb_to_mem_ready);
    assign accept          = ex_to_mem_valid && mem_to_ex_ready;

    // Next-state logic: a new op can start from IDLE or from the OUT
    // handshake cycle, which keeps ALU ops flowing at one per cycle
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        st_d       = st_q;
        alu_d      = alu_q;
        rd_d       = rd_q;
        regw_d     = regw_q;
        load_d     = load_q;
        out_data_d = out_data_q;
        out_rd_d   = out_rd_q;
        out_w_d    = out_w_q;
        misalign_d = 1'b0;

        case (state_q)
            ST_REQ: begin
                if (dmem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_resp_valid) begin
                    out_rd_d = rd_q;
                    if (load_q) begin
                        out_data_d = fmt_ld;
                        out_w_d    = regw_q;
                    end else begin
                        out_data_d = alu_q;
                        out_w_d    = 1'b0;
                    end
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (wb_to_mem_ready && !accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
            end
        endcase

        if (accept) begin
            funct3_d = in_funct3;
            addr_d   = in_memaddr;
            st_d     = in_stdata;
            alu_d    = in_alures;
            rd_d     = in_regaddr;
            regw_d   = in_regw;
            load_d   = in_ren;
            if (!in_ren && !in_wen) begin
                out_data_d = in_alures;
                out_rd_d   = in_regaddr;
                out_w_d    = in_regw;
                state_d    = ST_OUT;
            end else if (is_misaligned(in_funct3, in_memaddr[1:0], in_ren)) begin
                out_data_d = '0;
                out_rd_d   = in_regaddr;
                out_w_d    = 1'b0;
                misalign_d = 1'b1;
                state_d    = ST_OUT;
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            funct3_q   <= '0;
            addr_q     <= '0;
            st_q       <= '0;
            alu_q      <= '0;
            rd_q       <= '0;
            regw_q     <= 1'b0;
            load_q     <= 1'b0;
            out_data_q <= '0;
            out_rd_q   <= '0;
            out_w_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            st_q       <= st_d;
            alu_q      <= alu_d;
            rd_q       <= rd_d;
            regw_q     <= regw_d;
            load_q     <= load_d;
            out_data_q <= out_data_d;
            out_rd_q   <= out_rd_d;
            out_w_q    <= out_w_d;
            misalign_q <= misalign_d;
        end
    end

    assign dmem_req_valid  = (state_q == ST_REQ);
    assign dmem_req_wen    = !load_q;
    assign dmem_req_addr   = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign dmem_req_wdata  = fmt_wdata;
    assign dmem_req_wmask  = fmt_wmask;
    assign dmem_resp_ready = (state_q == ST_WAIT);
    assign mem_to_wb_valid = (state_q == ST_OUT);
    assign mem_to_wb_bus   = {out_data_q, out_rd_q, out_w_q};
    assign mem_misalign    = misalign_q;

endmodule

// File: tb/tb_memu.sv
// Directed self-checking bench for the memory-access stage.
module tb_memu;

    logic         clk;
    logic         rst;
    logic [106:0] ex_to_mem_bus;
    logic         ex_to_mem_valid;
    logic         mem_to_ex_ready;
    logic [37:0]  mem_to_wb_bus;
    logic         mem_to_wb_valid;
    logic         wb_to_mem_ready;
    logic         dmem_req_valid;
    logic         dmem_req_ready;
    logic         dmem_req_wen;
    logic [31:0]  dmem_req_addr;
    logic [31:0]  dmem_req_wdata;
    logic [3:0]   dmem_req_wmask;
    logic         dmem_resp_valid;
    logic [31:0]  dmem_resp_rdata;
    logic         dmem_resp_ready;
    logic         mem_misalign;

    int checks = 0;
    int errors = 0;

    memu dut (
        .clk             (clk),
        .rst             (rst),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_mem_valid (ex_to_mem_valid),
        .mem_to_ex_ready (mem_to_ex_ready),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_wb_valid (mem_to_wb_valid),
        .wb_to_mem_ready (wb_to_mem_ready),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_wen    (dmem_req_wen),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wmask  (dmem_req_wmask),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .dmem_resp_ready (dmem_resp_ready),
        .mem_misalign    (mem_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [106:0] make_ex(input logic ren, input logic wen,
                                             input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] st, input logic [31:0] alu,
                                             input logic [4:0] rd, input logic w);
        return {ren, wen, f3, addr, st, alu, rd, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_valid got %b exp 0", mem_to_wb_valid); end
        checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid got %b exp 0", dmem_req_valid); end
        checks++; if (dmem_resp_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_ready got %b exp 0", dmem_resp_ready); end
        checks++; if (mem_misalign !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign got %b exp 0", mem_misalign); end
        checks++; if (mem_to_wb_bus !== 38'h0) begin errors++; $display("[TB] FAIL reset_wb_bus got %h exp 0", mem_to_wb_bus); end
        checks++; if (mem_to_ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ex_ready got %b exp 1", mem_to_ex_ready); end
        #20;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = make_ex(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1);
        checks++; if (mem_to_ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL alu_ready got %b exp 1", mem_to_ex_ready); end
        tick();
        ex_to_mem_valid = 1'b0;
        checks++; if (mem_to_wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL alu_valid got %b exp 1", mem_to_wb_valid); end
        checks++; if (mem_to_wb_bus !== {32'h1234, 5'd5, 1'b1}) begin errors++; $display("[TB] FAIL alu_bus got %h exp %h", mem_to_wb_bus, {32'h1234, 5'd5, 1'b1}); end
        tick();
        checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL alu_idle got %b exp 0", mem_to_wb_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        logic [4:0]  rds  [3];
        vals = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
        rds  = '{5'd1, 5'd2, 5'd3};
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = make_ex(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, vals[0], rds[0], 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_to_wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d] got %b exp 1", i, mem_to_wb_valid); end
            checks++; if (mem_to_wb_bus !== {vals[i], rds[i], 1'b1}) begin errors++; $display("[TB] FAIL b2b_bus[%0d] got %h exp %h", i, mem_to_wb_bus, {vals[i], rds[i], 1'b1}); end
            if (i < 2) ex_to_mem_bus = make_ex(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, vals[i+1], rds[i+1], 1'b1);
            else       ex_to_mem_valid = 1'b0;
        end
        tick();
        checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end got %b exp 0", mem_to_wb_valid); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s   [5];
        logic [31:0] addrs [5];
        logic [31:0] rdat  [5];
        logic [31:0] expd  [5];
        f3s   = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101};
        addrs = '{32'h80000003, 32'h80000003, 32'h80000002, 32'h80000004, 32'h80000000};
        rdat  = '{32'h80FF0000, 32'h80FF0000, 32'h80011234, 32'hDEADBEEF, 32'h1234F00D};
        expd  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'hDEADBEEF, 32'h0000F00D};
        for (int i = 0; i < 5; i++) begin
            ex_to_mem_valid = 1'b1;
            ex_to_mem_bus   = make_ex(1'b1, 1'b0, f3s[i], addrs[i], 32'h0, 32'h0, 5'd7, 1'b1);
            tick();
            ex_to_mem_valid = 1'b0;
            checks++; if (dmem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL ld_req_valid[%0d] got %b exp 1", i, dmem_req_valid); end
            checks++; if (dmem_req_addr !== {addrs[i][31:2], 2'b00}) begin errors++; $display("[TB] FAIL ld_req_addr[%0d] got %h exp %h", i, dmem_req_addr, {addrs[i][31:2], 2'b00}); end
            checks++; if (dmem_req_wen !== 1'b0) begin errors++; $display("[TB] FAIL ld_req_wen[%0d] got %b exp 0", i, dmem_req_wen); end
            dmem_req_ready = 1'b1;
            tick();
            dmem_req_ready = 1'b0;
            checks++; if (dmem_resp_ready !== 1'b1) begin errors++; $display("[TB] FAIL ld_resp_ready[%0d] got %b exp 1", i, dmem_resp_ready); end
            dmem_resp_valid = 1'b1;
            dmem_resp_rdata = rdat[i];
            tick();
            dmem_resp_valid = 1'b0;
            checks++; if (mem_to_wb_bus !== {expd[i], 5'd7, 1'b1}) begin errors++; $display("[TB] FAIL ld_bus[%0d] got %h exp %h", i, mem_to_wb_bus, {expd[i], 5'd7, 1'b1}); end
            tick();
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3s   [2];
        logic [31:0] addrs [2];
        logic [31:0] sts   [2];
        logic [31:0] wds   [2];
        logic [3:0]  wms   [2];
        f3s   = '{3'b001, 3'b000};
        addrs = '{32'h80000002, 32'h80000001};
        sts   = '{32'h5555ABCD, 32'h123456EF};
        wds   = '{32'hABCDABCD, 32'hEFEFEFEF};
        wms   = '{4'b1100, 4'b0010};
        for (int i = 0; i < 2; i++) begin
            ex_to_mem_valid = 1'b1;
            ex_to_mem_bus   = make_ex(1'b0, 1'b1, f3s[i], addrs[i], sts[i], addrs[i], 5'd3, 1'b1);
            tick();
            ex_to_mem_valid = 1'b0;
            checks++; if (dmem_req_wen !== 1'b1) begin errors++; $display("[TB] FAIL st_wen[%0d] got %b exp 1", i, dmem_req_wen); end
            checks++; if (dmem_req_addr !== 32'h80000000) begin errors++; $display("[TB] FAIL st_addr[%0d] got %h exp 80000000", i, dmem_req_addr); end
            checks++; if (dmem_req_wmask !== wms[i]) begin errors++; $display("[TB] FAIL st_wmask[%0d] got %b exp %b", i, dmem_req_wmask, wms[i]); end
            checks++; if (dmem_req_wdata !== wds[i]) begin errors++; $display("[TB] FAIL st_wdata[%0d] got %h exp %h", i, dmem_req_wdata, wds[i]); end
            dmem_req_ready = 1'b1;
            tick();
            dmem_req_ready  = 1'b0;
            dmem_resp_valid = 1'b1;
            dmem_resp_rdata = 32'h0BADF00D;
            tick();
            dmem_resp_valid = 1'b0;
            checks++; if (mem_to_wb_bus !== {addrs[i], 5'd3, 1'b0}) begin errors++; $display("[TB] FAIL st_bus[%0d] got %h exp %h", i, mem_to_wb_bus, {addrs[i], 5'd3, 1'b0}); end
            tick();
        end
    endtask

    task automatic test_stall();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = make_ex(1'b1, 1'b0, 3'b010, 32'h80000008, 32'h0, 32'h0, 5'd9, 1'b1);
        tick();
        ex_to_mem_bus   = make_ex(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h77, 5'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (dmem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_req_valid[%0d] got %b exp 1", i, dmem_req_valid); end
            checks++; if (dmem_req_addr !== 32'h80000008) begin errors++; $display("[TB] FAIL stall_req_addr[%0d] got %h exp 80000008", i, dmem_req_addr); end
            checks++; if (mem_to_ex_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ex_ready[%0d] got %b exp 0", i, mem_to_ex_ready); end
            tick();
        end
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_req_valid[%0d] got %b exp 0", i, dmem_req_valid); end
            checks++; if (dmem_resp_ready !== 1'b1) begin errors++; $display("[TB] FAIL wait_resp_ready[%0d] got %b exp 1", i, dmem_resp_ready); end
            checks++; if (mem_to_ex_ready !== 1'b0) begin errors++; $display("[TB] FAIL wait_ex_ready[%0d] got %b exp 0", i, mem_to_ex_ready); end
            tick();
        end
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h11223344;
        ex_to_mem_valid = 1'b0;
        tick();
        dmem_resp_valid = 1'b0;
        checks++; if (mem_to_wb_bus !== {32'h11223344, 5'd9, 1'b1}) begin errors++; $display("[TB] FAIL stall_bus got %h exp %h", mem_to_wb_bus, {32'h11223344, 5'd9, 1'b1}); end
        checks++; if (mem_to_ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_out_ready got %b exp 1", mem_to_ex_ready); end
        tick();
    endtask

    task automatic test_misalign();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = make_ex(1'b1, 1'b0, 3'b010, 32'h80000002, 32'h0, 32'h55, 5'd4, 1'b1);
        wb_to_mem_ready = 1'b0;
        tick();
        ex_to_mem_valid = 1'b0;
        checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_req_valid got %b exp 0", dmem_req_valid); end
        checks++; if (mem_misalign !== 1'b1) begin errors++; $display("[TB] FAIL mis_pulse got %b exp 1", mem_misalign); end
        checks++; if (mem_to_wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL mis_valid got %b exp 1", mem_to_wb_valid); end
        checks++; if (mem_to_wb_bus !== {32'h0, 5'd4, 1'b0}) begin errors++; $display("[TB] FAIL mis_bus got %h exp %h", mem_to_wb_bus, {32'h0, 5'd4, 1'b0}); end
        tick();
        checks++; if (mem_misalign !== 1'b0) begin errors++; $display("[TB] FAIL mis_pulse_len got %b exp 0", mem_misalign); end
        checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_req_valid2 got %b exp 0", dmem_req_valid); end
        wb_to_mem_ready = 1'b1;
        tick();
    endtask

    task automatic test_wb_stall();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = make_ex(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hCAFEF00D, 5'd31, 1'b1);
        wb_to_mem_ready = 1'b0;
        tick();
        ex_to_mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_to_wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL wbst_valid[%0d] got %b exp 1", i, mem_to_wb_valid); end
            checks++; if (mem_to_wb_bus !== {32'hCAFEF00D, 5'd31, 1'b1}) begin errors++; $display("[TB] FAIL wbst_bus[%0d] got %h exp %h", i, mem_to_wb_bus, {32'hCAFEF00D, 5'd31, 1'b1}); end
            checks++; if (mem_to_ex_ready !== 1'b0) begin errors++; $display("[TB] FAIL wbst_ex_ready[%0d] got %b exp 0", i, mem_to_ex_ready); end
            tick();
        end
        wb_to_mem_ready = 1'b1;
        #1;
        checks++; if (mem_to_ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL wbst_release got %b exp 1", mem_to_ex_ready); end
        tick();
        checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL wbst_idle got %b exp 0", mem_to_wb_valid); end
    endtask

    task automatic test_reset_mid();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = make_ex(1'b1, 1'b0, 3'b010, 32'h80000010, 32'h0, 32'h0, 5'd2, 1'b1);
        tick();
        ex_to_mem_valid = 1'b0;
        dmem_req_ready  = 1'b1;
        tick();
        dmem_req_ready  = 1'b0;
        checks++; if (dmem_resp_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_wait got %b exp 1", dmem_resp_ready); end
        rst = 1'b0;
        #1;
        checks++; if (dmem_resp_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_resp_ready got %b exp 0", dmem_resp_ready); end
        checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_req_valid got %b exp 0", dmem_req_valid); end
        checks++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_wb_valid got %b exp 0", mem_to_wb_valid); end
        checks++; if (mem_to_wb_bus !== 38'h0) begin errors++; $display("[TB] FAIL rstmid_bus got %h exp 0", mem_to_wb_bus); end
        #3;
        rst = 1'b1;
        tick();
        checks++; if (mem_to_ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ex_ready got %b exp 1", mem_to_ex_ready); end
        checks++; if (dmem_resp_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_idle_resp got %b exp 0", dmem_resp_ready); end
    endtask

    initial begin
        rst             = 1'b0;
        ex_to_mem_bus   = '0;
        ex_to_mem_valid = 1'b0;
        wb_to_mem_ready = 1'b1;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = '0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_loads();
        test_stores();
        test_stall();
        test_misalign();
        test_wb_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
